// File: rtl/pc_branch_unit_pkg.sv
// Shared CPU definitions used by the program-counter / branch unit.
//   cond_t      : branch condition selected by the decoder
//   kREL_BRANCH : destination is pc + sign-extended offset
//   kABS_BRANCH : destination is the absolute target
//   flag_t      : registered CMP result {lt, eq, gt}, one-hot after a CMP
//   pc_state_t  : run / halt state of the PC sequencer
package pc_branch_unit_pkg;

  typedef enum logic [1:0] {
    COND_NONE = 2'd0,
    COND_EQ   = 2'd1,
    COND_LT   = 2'd2,
    COND_GT   = 2'd3
  } cond_t;

  localparam logic kREL_BRANCH = 1'b0;
  localparam logic kABS_BRANCH = 1'b1;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } flag_t;

  typedef enum logic {
    PC_RUN  = 1'b0,
    PC_HALT = 1'b1
  } pc_state_t;

  // True when the decoder's condition is satisfied by the stored flags.
  // COND_NONE never branches.
  function automatic logic cond_met(input cond_t c, input flag_t f);
    logic met;
    met = 1'b0;
    unique case (c)
      COND_EQ:   met = f.eq;
      COND_LT:   met = f.lt;
      COND_GT:   met = f.gt;
      default:   met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/pc_branch_unit_ras.sv
// Return-address stack: circular LIFO of DEPTH entries, each W bits wide.
// A push onto a full stack overwrites the oldest entry (the write pointer
// simply wraps), so the most recent DEPTH return addresses survive.
// A pop on an empty stack is ignored; the caller handles underflow.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i at the top
//   pop_i        : discard the top entry (ignored when push_i is high)
//   push_data_i  : return address to store
//   top_o        : current top entry (valid when !empty_o)
//   count_o      : live entries, 0..DEPTH
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
module ras_stack
  import pc_branch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 10,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     push_data_i,
  output logic [W-1:0]     top_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;     // next slot to write; top is sp_q-1
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == CNT_MAX);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  // DEPTH is a power of two, so the pointer wraps naturally.
  assign top_o   = mem_q[sp_q - PTR_ONE];

  // NOTE: every variable gets a default before any branch so the
  // combinational block can never infer a latch.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push_i) begin
      sp_d = sp_q + PTR_ONE;
      if (!full_o) cnt_d = cnt_q + CNT_ONE;
    end else if (pop_i && !empty_o) begin
      sp_d  = sp_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; entries are
  // only read once count_o says they were written, and an unreset array
  // maps onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[sp_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter and branch unit.
// Owns the PC, the CMP flag register, branch-condition evaluation,
// relative/absolute redirects, a return-address stack for CALL/RET and a
// HALT state. One PC action per enabled cycle, highest priority first:
// halt_req, ret, call, taken branch, sequential step.
//   clk, rst_n       : clock, asynchronous active-low reset
//   en               : advance; 0 freezes all state
//   cmp_valid, cmp_a, cmp_b : CMP instruction loading the flags
//   cond             : branch condition (COND_NONE = no branch)
//   abs_mode         : kABS_BRANCH uses target, kREL_BRANCH uses pc+offset
//   target, offset   : absolute destination / signed displacement
//   call, ret        : subroutine call / return
//   halt_req         : enter HALT (left only through reset)
//   pc               : current program counter
//   flags            : registered {lt, eq, gt}
//   redirect         : 1 for the cycle after a non-sequential PC update
//   halted           : 1 while in HALT
//   ras_count        : live return-stack entries
//   ras_ovf, ras_unf : sticky stack overflow / underflow
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int OFF_W      = 6,
  parameter int DATA_W     = 8,
  parameter int RAS_DEPTH  = 4,
  parameter int RESET_PC   = 0,
  parameter int SIGNED_CMP = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         cmp_valid,
  input  logic [DATA_W-1:0]            cmp_a,
  input  logic [DATA_W-1:0]            cmp_b,
  input  cond_t                        cond,
  input  logic                         abs_mode,
  input  logic [PC_W-1:0]              target,
  input  logic [OFF_W-1:0]             offset,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         halt_req,
  output logic [PC_W-1:0]              pc,
  output logic [2:0]                   flags,
  output logic                         redirect,
  output logic                         halted,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);
  localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_PC);

  pc_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  flag_t           flags_q, flags_d;
  logic            redirect_q, redirect_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            ras_push, ras_pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_full, ras_empty;

  // ---------------------------------------------------------------------
  // CMP: one-hot {lt, eq, gt}, signedness fixed at elaboration.
  // ---------------------------------------------------------------------
  logic  cmp_lt, cmp_eq;
  flag_t cmp_flags;

  generate
    if (SIGNED_CMP != 0) begin : g_signed_cmp
      assign cmp_lt = ($signed(cmp_a) < $signed(cmp_b));
    end else begin : g_unsigned_cmp
      assign cmp_lt = (cmp_a < cmp_b);
    end
  endgenerate

  assign cmp_eq       = (cmp_a == cmp_b);
  assign cmp_flags.lt = cmp_lt;
  assign cmp_flags.eq = cmp_eq;
  assign cmp_flags.gt = !cmp_lt && !cmp_eq;

  // ---------------------------------------------------------------------
  // Destination arithmetic, all modulo 2^PC_W.
  // ---------------------------------------------------------------------
  logic [PC_W-1:0] pc_inc, off_sext, branch_dest;

  assign pc_inc      = pc_q + PC_ONE;
  // Size cast of a signed operand sign-extends, and also works when
  // OFF_W == PC_W (no zero-width replication).
  assign off_sext    = PC_W'($signed(offset));
  assign branch_dest = (abs_mode == kABS_BRANCH) ? target : (pc_q + off_sext);

  // ---------------------------------------------------------------------
  // Next-state / action selection.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flags_d    = flags_q;
    redirect_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;

    if (en && (state_q == PC_RUN)) begin
      // The CMP result lands in parallel with the PC action; the branch
      // below still sees the flags from before this cycle.
      if (cmp_valid) flags_d = cmp_flags;

      if (halt_req) begin
        state_d = PC_HALT;
      end else if (ret) begin
        if (!ras_empty) begin
          ras_pop    = 1'b1;
          pc_d       = ras_top;
          redirect_d = 1'b1;
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (call) begin
        ras_push   = 1'b1;
        pc_d       = branch_dest;
        redirect_d = 1'b1;
        if (ras_full) ovf_d = 1'b1;
      end else if (cond_met(cond, flags_q)) begin
        pc_d       = branch_dest;
        redirect_d = 1'b1;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PC_RUN;
      pc_q       <= PC_RESET;
      flags_q    <= '0;
      redirect_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flags_q    <= flags_d;
      redirect_q <= redirect_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_inc),
    .top_o       (ras_top),
    .count_o     (ras_count),
    .full_o      (ras_full),
    .empty_o     (ras_empty)
  );

  assign pc       = pc_q;
  assign flags    = flags_q;
  assign redirect = redirect_q;
  assign halted   = (state_q == PC_HALT);
  assign ras_ovf  = ovf_q;
  assign ras_unf  = unf_q;

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Parametrised successor to the CPU's fixed 4-bit branch scheme: owns the program counter, the CMP flag register, branch-condition evaluation (cond_t), relative/absolute redirect, a return-address stack (CALL/RET) and a HALT state.
- Sits between the decoder (supplies cond/mode/target/offset/call/ret) and instruction memory (consumes pc).
- One PC update per enabled cycle.

Parameters:
- PC_W, 10, program counter width in bits.
- OFF_W, 6, signed relative branch offset width; must be less than or equal to PC_W.
- DATA_W, 8, CMP operand width.
- RAS_DEPTH, 4, return-address stack entries; power of two, at least 2.
- RESET_PC, 0, PC value loaded on reset.
- SIGNED_CMP, 0, 1 = two's-complement CMP compare; 0 = unsigned compare.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance; when 0, all state holds.
- cmp_valid  in  1  a CMP instruction is executing this cycle.
- cmp_a  in  DATA_W  CMP left operand.
- cmp_b  in  DATA_W  CMP right operand.
- cond  in  2  cond_t branch condition; COND_NONE means no branch.
- abs_mode  in  1  kABS_BRANCH (1) uses target; kREL_BRANCH (0) uses pc+offset.
- target  in  PC_W  absolute destination.
- offset  in  OFF_W  signed relative displacement.
- call  in  1  unconditional call.
- ret  in  1  return.
- halt_req  in  1  enter HALT.
- pc  out  PC_W  current program counter (registered).
- flags  out  3  registered {lt,eq,gt}.
- redirect  out  1  registered; 1 for the cycle after a non-sequential PC update.
- halted  out  1  registered; 1 while in HALT.
- ras_count  out  clog2(RAS_DEPTH)+1  live stack entries.
- ras_ovf  out  1  sticky; a call was made while the stack was full.
- ras_unf  out  1  sticky; a ret was made while the stack was empty.

Behaviour:
- Reset (async on rst_n=0):
  - pc=RESET_PC; flags=3'b000; redirect=0; halted=0; ras_count=0; ras_ovf=0; ras_unf=0; stack pointer=0; state=RUN.
  - Stack contents are don't-care.
- FSM has two states, RUN and HALT.
  - In RUN with en=1 and halt_req=1: go to HALT. pc holds, halted=1 from the next cycle.
  - HALT holds every register. Only reset leaves HALT.
- In RUN with en=1, one action is taken per cycle, in this priority order:
  - 1. halt_req.
  - 2. ret: pc = popped entry. If empty: pc=pc+1 and ras_unf is set.
  - 3. call: push pc+1, then pc = abs_mode ? target : pc+sext(offset).
  - 4. Branch taken, when cond=COND_EQ and eq, or COND_LT and lt, or COND_GT and gt: pc = abs_mode ? target : pc+sext(offset).
  - 5. Otherwise pc=pc+1.
- Condition evaluation uses the registered flags only. A cmp_valid in the same cycle as a branch does not affect that branch.
- Flag update: when en=1 and cmp_valid=1, flags load a one-hot compare of cmp_a vs cmp_b, signed if SIGNED_CMP=1. This happens in parallel with any PC action, except in HALT.
- All PC arithmetic is modulo 2^PC_W. pc+1 wraps from all-ones to 0. The relative target is sign-extended offset added to the current pc, with wrap.
- Stack (circular):
  - Push at a full stack overwrites the oldest entry. ras_count stays RAS_DEPTH and ras_ovf is set.
  - Pop decrements ras_count.
  - If call and ret are asserted together, only ret acts.
- redirect=1 the cycle after rule 2 with a non-empty stack, rule 3, or rule 4. Otherwise 0. It is also 0 while en=0.
- en=0: no state changes, cmp_valid is ignored, redirect=0.
- Latency: every output is registered, so an input's effect is visible on the following cycle.

Decomposition:
- Shared package (extends the CPU definitions package):
  - cond_t, kREL_BRANCH and kABS_BRANCH (existing).
  - New flag_t packed struct {lt,eq,gt}.
  - New pc_state_t enum {PC_RUN, PC_HALT}.
- One sub-module, ras_stack: a parametrised circular LIFO with push/pop/count/full/empty, holding RAS_DEPTH entries of PC_W bits.

Test Plan:
- Reset and sequential stepping: reset with RESET_PC=10, then en=1 for 3 cycles -> pc=10,11,12,13. With PC_W=4 and pc=15, one step -> pc=0.
- CMP then branch: cmp_valid, cmp_a=3, cmp_b=7 -> flags=100. Next cycle cond=COND_LT, abs_mode=0, offset=-2, pc=20 -> pc=18 and redirect=1. Then cond=COND_GT -> pc=19.
- Same-cycle hazard and signedness: SIGNED_CMP=1, cmp_a=8'hFF, cmp_b=1 -> lt set. Repeat with SIGNED_CMP=0 -> gt set. A branch issued in the same cycle as the CMP uses the old flags.
- Call/return nesting: call target=100 at pc=5, then call target=200 at pc=100, then ret, ret -> pc sequence 100, 200, 101, 6, with ras_count going 1, 2, 1, 0.
- Stack boundaries: RAS_DEPTH=4, five calls -> ras_ovf=1, count=4, and the first return address is lost. ret on an empty stack -> pc+1, ras_unf=1, redirect=0.
- Halt, stall and mid-operation reset: en=0 for 3 cycles -> pc held. halt_req -> halted=1 and pc frozen, even with call asserted. Assert rst_n=0 mid-HALT -> outputs return to reset values immediately (asynchronously).
